// File: rtl/traffic_pkg.sv
// Shared types for the highway/country traffic-light controller.
//   state_t    : controller FSM states
//   RED/YELLOW/GREEN : lamp codes driven on hwy/cntry
//   STOP/HRGO/CRGO/TIMER : displaySignal codes for the countdown datapath
//   ctrlOut_t  : bundle of all registered controller outputs
//   decodeOut  : per-state output decode (applied to the next state)
package traffic_pkg;

  typedef enum logic [2:0] {
    H_LOAD, H_GREEN, H_YELLOW, C_LOAD, C_GREEN, C_YELLOW, FAULT
  } state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam logic [1:0] STOP  = 2'b11;
  localparam logic [1:0] HRGO  = 2'b01;
  localparam logic [1:0] CRGO  = 2'b00;
  localparam logic [1:0] TIMER = 2'b10;

  localparam int TMR_W = 27;

  typedef struct packed {
    logic       load;
    logic       twentyToLoad;
    logic [1:0] displaySignal;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       fault;
  } ctrlOut_t;

  // Output values held while reset is asserted.
  localparam ctrlOut_t RESET_OUT = '{load: 1'b0, twentyToLoad: 1'b1,
                                     displaySignal: HRGO, hwy: GREEN,
                                     cntry: RED, fault: 1'b0};

  function automatic logic isLoad(input state_t s);
    return (s == H_LOAD) || (s == C_LOAD);
  endfunction

  function automatic logic inCountry(input state_t s);
    return (s == C_LOAD) || (s == C_GREEN) || (s == C_YELLOW);
  endfunction

  // twentyToLoad follows the phase: 1 on the highway side, 0 on the
  // country side, so it is already settled whenever load rises.
  function automatic ctrlOut_t decodeOut(input state_t s);
    ctrlOut_t o;
    o = '{load: 1'b0, twentyToLoad: 1'b1, displaySignal: STOP,
          hwy: RED, cntry: RED, fault: 1'b0};
    case (s)
      H_LOAD:   begin o.load = 1'b1; o.displaySignal = HRGO; o.hwy = GREEN; end
      H_GREEN:  begin o.displaySignal = HRGO;  o.hwy = GREEN;  end
      H_YELLOW: begin o.displaySignal = TIMER; o.hwy = YELLOW; end
      C_LOAD:   begin
        o.load = 1'b1; o.twentyToLoad = 1'b0;
        o.displaySignal = CRGO; o.cntry = GREEN;
      end
      C_GREEN:  begin o.twentyToLoad = 1'b0; o.displaySignal = CRGO;  o.cntry = GREEN;  end
      C_YELLOW: begin o.twentyToLoad = 1'b0; o.displaySignal = TIMER; o.cntry = YELLOW; end
      FAULT:    begin o.displaySignal = STOP; o.fault = 1'b1; end
      default:  ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/traffic_ctrl_fsm_sync.sv
// N-flop level synchroniser for asynchronous / slow-domain inputs.
//   clk  : destination clock
//   rstN : asynchronous active-low reset, clears every stage to 0
//   d    : asynchronous input
//   q    : synchronised output, STAGES cycles of latency
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/traffic_ctrl_fsm.sv
// Highway/country-road traffic-light controller feeding the countdown datapath.
// Optional feature macro: TRAFFIC_CAR_SENSOR_EN (highway stays green until a
// country car is seen; when undefined the cycle is fixed and carSensor ignored).
// Ports:
//   CLOCK_50       : system clock
//   reset          : asynchronous active-low reset
//   carSensor      : country-road vehicle detect (asynchronous level)
//   counterNotZero : datapath count != 0 (slow domain)
//   counterNotFive : datapath count != 5 (slow domain)
//   load           : load request, held until the datapath acknowledges
//   twentyToLoad   : 1 = load 20 s, 0 = load 10 s
//   displaySignal  : datapath display mode
//   hwy / cntry    : lamp codes
//   fault          : sticky load-timeout indicator
module traffic_ctrl_fsm
  import traffic_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 100000000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       carSensor,
  input  logic       counterNotZero,
  input  logic       counterNotFive,
  output logic       load,
  output logic       twentyToLoad,
  output logic [1:0] displaySignal,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       fault
);

  // ---- input synchronisers -------------------------------------------------
  logic [1:0] flagSync;
  logic       counterNotZero_s, counterNotFive_s;

  sync_nff #(.STAGES(SYNC_STAGES)) uFlagSync [1:0] (
    .clk  (CLOCK_50),
    .rstN (reset),
    .d    ({counterNotZero, counterNotFive}),
    .q    (flagSync)
  );

  assign counterNotZero_s = flagSync[1];
  assign counterNotFive_s = flagSync[0];

  // A fresh load (20 or 10) makes both flags true; that is the acknowledge.
  logic ack;
  assign ack = counterNotZero_s & counterNotFive_s;

  // ---- state ----------------------------------------------------------------
  state_t           state, nextState;
  ctrlOut_t         outReg, nextOut;
  logic [TMR_W-1:0] loadTmr;
  logic             loadTimeout;
  logic             carWaiting;
  logic             enterCLoad;

  assign loadTimeout = (loadTmr >= TMR_W'(LOAD_TIMEOUT - 1));
  assign enterCLoad  = (nextState == C_LOAD) && (state != C_LOAD);

  always_comb begin
    nextState = state;
    case (state)
      H_LOAD:   if (ack) nextState = H_GREEN;
                else if (loadTimeout) nextState = FAULT;
      H_GREEN:  if (!counterNotFive_s) nextState = carWaiting ? H_YELLOW : H_LOAD;
      H_YELLOW: if (!counterNotZero_s) nextState = C_LOAD;
      C_LOAD:   if (ack) nextState = C_GREEN;
                else if (loadTimeout) nextState = FAULT;
      C_GREEN:  if (!counterNotFive_s) nextState = C_YELLOW;
      C_YELLOW: if (!counterNotZero_s) nextState = H_LOAD;
      FAULT:    nextState = FAULT;
      default:  nextState = H_LOAD;
    endcase
    // Outputs are registered from the next state so they switch together
    // with the state register.
    nextOut = decodeOut(nextState);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state   <= H_LOAD;
      outReg  <= RESET_OUT;
      loadTmr <= '0;
    end else begin
      state  <= nextState;
      outReg <= nextOut;
      // Restart on every entry into a LOAD state (including the H_GREEN
      // re-arm), count while waiting for ack, hold at all-ones.
      if (isLoad(nextState) && (nextState != state))
        loadTmr <= '0;
      else if (isLoad(state) && (loadTmr != '1))
        loadTmr <= loadTmr + 1'b1;
    end
  end

  // ---- car detection -------------------------------------------------------
`ifdef TRAFFIC_CAR_SENSOR_EN
  logic carSensor_s;

  sync_nff #(.STAGES(SYNC_STAGES)) uCarSync (
    .clk  (CLOCK_50),
    .rstN (reset),
    .d    (carSensor),
    .q    (carSensor_s)
  );

  // Clear takes priority so a car seen on the C_LOAD entry edge is dropped.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset)                                carWaiting <= 1'b0;
    else if (enterCLoad)                       carWaiting <= 1'b0;
    else if (carSensor_s && !inCountry(state)) carWaiting <= 1'b1;
  end
`else
  // Fixed cycle: H_GREEN always hands over to the country road.
  logic unusedCarInputs;
  assign unusedCarInputs = carSensor ^ enterCLoad;
  assign carWaiting      = 1'b1;
`endif

  // ---- outputs ---------------------------------------------------------------
  assign load          = outReg.load;
  assign twentyToLoad  = outReg.twentyToLoad;
  assign displaySignal = outReg.displaySignal;
  assign hwy           = outReg.hwy;
  assign cntry         = outReg.cntry;
  assign fault         = outReg.fault;

  // Conflicting greens/yellows must never be shown.
  lampExclusive: assert property (@(posedge CLOCK_50) disable iff (!reset)
                                  (hwy == RED) || (cntry == RED));

endmodule

// File: tb/tb_traffic_ctrl_fsm.sv
module tb_traffic_ctrl_fsm;

  localparam int SYNC      = 2;
  localparam int TMO       = 16;
  localparam int LOAD_HIGH = SYNC + 2;  // load edge -> model load -> 2 sync flops -> FSM edge
  localparam int WAIT_MAX  = 6000;

  // Output vector {load, twenty, disp[1:0], hwy[1:0], cntry[1:0], fault}
  localparam logic [8:0] V_HL = {1'b1, 1'b1, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [8:0] V_HG = {1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [8:0] V_HY = {1'b0, 1'b1, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [8:0] V_CL = {1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [8:0] V_CG = {1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [8:0] V_CY = {1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0};
  localparam logic [8:0] V_FL = {1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [8:0] V_RS = {1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 1'b0};

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       carSensor = 1'b0;
  logic       counterNotZero, counterNotFive;
  logic       load, twentyToLoad, fault;
  logic [1:0] displaySignal, hwy, cntry;

  traffic_ctrl_fsm #(.LOAD_TIMEOUT(TMO), .SYNC_STAGES(SYNC)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .carSensor     (carSensor),
    .counterNotZero(counterNotZero),
    .counterNotFive(counterNotFive),
    .load          (load),
    .twentyToLoad  (twentyToLoad),
    .displaySignal (displaySignal),
    .hwy           (hwy),
    .cntry         (cntry),
    .fault         (fault)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // ---- datapath model: down-counter stepping every 8 clocks --------------------
  int   count = 0;
  int   pre   = 0;
  logic ignoreLoad = 1'b0;

  always @(posedge CLOCK_50) begin
    if (!reset) begin
      count <= 0;
      pre   <= 0;
    end else begin
      pre <= (pre + 1) % 8;
      if (load && !ignoreLoad)      count <= twentyToLoad ? 20 : 10;
      else if (pre == 7 && count > 0) count <= count - 1;
    end
  end

  assign counterNotZero = (count != 0);
  assign counterNotFive = (count != 5);

  // ---- scoreboard ------------------------------------------------------------------
  int         checks = 0;
  int         errors = 0;
  int         nSeen  = 0;
  int         cyc    = 0;
  int         loadRise = 0;
  logic [8:0] expQ[$];
  logic [8:0] prevV = V_RS;

  task automatic checkI(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic checkV(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b (item %0d)", name, got, want, nSeen);
    end
  endtask

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Every change of the output vector is one DUT "presentation".
  always @(negedge CLOCK_50) begin
    logic [8:0] curV;
    logic [8:0] expV;
    curV = {load, twentyToLoad, displaySignal, hwy, cntry, fault};
    if (curV !== prevV) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change got %b want no change", curV);
      end else begin
        expV = expQ.pop_front();
        checkV("transition", curV, expV);
      end
      nSeen++;
      if (load && !prevV[8]) loadRise = cyc;
      if (!load && prevV[8] && !fault && reset) checkI("load_high_cycles", cyc - loadRise, LOAD_HIGH);
      if (fault && !prevV[0]) checkI("timeout_cycles", cyc - loadRise, TMO);
    end
    prevV = curV;
  end

  task automatic finishRun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic waitSeen(input int n);
    int k = 0;
    while (nSeen < n && k < WAIT_MAX) begin
      @(posedge CLOCK_50);
      k++;
    end
    if (nSeen < n) begin
      checks++;
      errors++;
      $display("FAIL wait_seen got %0d want %0d", nSeen, n);
      finishRun();
    end
  endtask

  task automatic checkResetVals();
    checkI("rst_load",  int'(load), 0);
    checkI("rst_twenty", int'(twentyToLoad), 1);
    checkI("rst_disp",  int'(displaySignal), 1);
    checkI("rst_hwy",   int'(hwy), 2);
    checkI("rst_cntry", int'(cntry), 0);
    checkI("rst_fault", int'(fault), 0);
  endtask

  task automatic pushCycle();
    expQ.push_back(V_HG); expQ.push_back(V_HY); expQ.push_back(V_CL);
    expQ.push_back(V_CG); expQ.push_back(V_CY); expQ.push_back(V_HL);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1 checkResetVals();

`ifdef TRAFFIC_CAR_SENSOR_EN
    // HL HG HL(re-arm) HG HY CL CG CY HL HG HL FL RS HL HG
    expQ.push_back(V_HL); expQ.push_back(V_HG); expQ.push_back(V_HL);
    expQ.push_back(V_HG); expQ.push_back(V_HY); expQ.push_back(V_CL);
    expQ.push_back(V_CG); expQ.push_back(V_CY); expQ.push_back(V_HL);
    expQ.push_back(V_HG); expQ.push_back(V_HL); expQ.push_back(V_FL);
    expQ.push_back(V_RS); expQ.push_back(V_HL); expQ.push_back(V_HG);
    @(negedge CLOCK_50) reset = 1'b1;

    waitSeen(4);                       // second HG: car arrives
    @(negedge CLOCK_50) carSensor = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    carSensor = 1'b0;

    waitSeen(7);                       // CG: car seen only here must not count
    @(negedge CLOCK_50) carSensor = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    carSensor = 1'b0;

    waitSeen(10);                      // HG: datapath stops answering loads
    ignoreLoad = 1'b1;
    waitSeen(12);
    repeat (40) @(negedge CLOCK_50);
    reset = 1'b0;
    ignoreLoad = 1'b0;
    waitSeen(13);
    #1 checkResetVals();
    @(negedge CLOCK_50) reset = 1'b1;
    waitSeen(15);
`else
    expQ.push_back(V_HL);
    repeat (4) pushCycle();
    expQ.push_back(V_FL); expQ.push_back(V_RS);
    expQ.push_back(V_HL); expQ.push_back(V_HG);
    @(negedge CLOCK_50) reset = 1'b1;

    waitSeen(23);                      // fourth CG: datapath stops answering
    ignoreLoad = 1'b1;
    waitSeen(26);
    repeat (40) @(negedge CLOCK_50);
    reset = 1'b0;
    ignoreLoad = 1'b0;
    waitSeen(27);
    #1 checkResetVals();
    @(negedge CLOCK_50) reset = 1'b1;
    waitSeen(29);
`endif

    repeat (20) @(posedge CLOCK_50);
    checkI("queue_empty", expQ.size(), 0);
    finishRun();
  end

endmodule
